lfsr_rand_gen: RTL and testbench

- Parametrised pseudo-random generator. It is the successor to the button-clocked 8-bit random source that drives the seven-segment display.
- A Fibonacci LFSR of configurable width runs on the system clock. It has two stepping modes:
  - free-run: one step every cycle.
  - button-step: a raw push-button input is synchronised and debounced on-chip, and each press gives exactly one step.
- Supports seed loading from switches and all-zero lock-up protection.
- Outputs feed the segment decoder and the LEDs.

---
 rtl/lfsr_rand_gen_pkg.sv | 46 ++++
 rtl/lfsr_rand_gen_btn_debounce.sv | 58 +++++
 rtl/lfsr_rand_gen.sv | 85 ++++++++
 tb/tb_lfsr_rand_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_rand_gen_pkg.sv
// Shared constants for the LFSR random generator: default maximal-length
// feedback masks (bit i set means state[i] feeds the XOR) for widths 4..32.
package lfsr_pkg;

   localparam int MIN_WIDTH = 4;
   localparam int MAX_WIDTH = 32;

   localparam logic [7:0]  TAPS_8  = 8'hB8;
   localparam logic [15:0] TAPS_16 = 16'hB400;

   function automatic logic [31:0] default_taps(input int width);
      case (width)
         4:       return 32'h0000_000C;
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         8:       return 32'(TAPS_8);
         9:       return 32'h0000_0110;
         10:      return 32'h0000_0240;
         11:      return 32'h0000_0500;
         12:      return 32'h0000_0829;
         13:      return 32'h0000_100D;
         14:      return 32'h0000_2015;
         15:      return 32'h0000_6000;
         16:      return 32'(TAPS_16);
         17:      return 32'h0001_2000;
         18:      return 32'h0002_0400;
         19:      return 32'h0004_0023;
         20:      return 32'h0009_0000;
         21:      return 32'h0014_0000;
         22:      return 32'h0030_0000;
         23:      return 32'h0042_0000;
         24:      return 32'h00E1_0000;
         25:      return 32'h0120_0000;
         26:      return 32'h0200_0023;
         27:      return 32'h0400_0013;
         28:      return 32'h0900_0000;
         29:      return 32'h1400_0000;
         30:      return 32'h2000_0029;
         31:      return 32'h4800_0000;
         32:      return 32'h8020_0003;
         default: return 32'(TAPS_8);
      endcase
   endfunction

endpackage

// File: rtl/lfsr_rand_gen_btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, hold-time debounce counter,
// debounced level and a one-cycle rising-edge pulse aligned with the level.
module btn_debounce
   import lfsr_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_rise
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          rise_q, rise_d;

   // Counter only advances while the synchronised input disagrees with the
   // accepted level; any agreement restarts the hold window.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      rise_d  = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
      end
   end

   assign btn_level = level_q;
   assign btn_rise  = rise_q;

endmodule

// File: rtl/lfsr_rand_gen.sv
// Fibonacci LFSR random source with free-run or debounced button stepping,
// seed loading, all-zero lock-up guard and a wrapping step counter.
module lfsr_rand_gen
   import lfsr_pkg::*;
#(
   parameter int               WIDTH           = 8,
   parameter logic [WIDTH-1:0] TAPS            = WIDTH'(default_taps(WIDTH)),
   parameter logic [WIDTH-1:0] SEED            = WIDTH'(1),
   parameter int               DEBOUNCE_CYCLES = 16,
   parameter int               CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step_btn,
   input  logic             free_run,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] rand_num,
   output logic             rand_valid,
   output logic [CNT_W-1:0] step_count,
   output logic             btn_level
);

   logic             btn_rise;
   logic             step_req;
   logic             fb;
   logic [WIDTH-1:0] next_state;
   logic [WIDTH-1:0] state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             valid_q, valid_d;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (step_btn),
      .btn_level(btn_level),
      .btn_rise (btn_rise)
   );

   // A button rise during free-run merges into the same single step.
   assign step_req = free_run | btn_rise;

   always_comb begin
      fb         = ^(state_q & TAPS);
      next_state = {state_q[WIDTH-2:0], fb};
      if (state_q == '0) begin
         next_state = SEED;
      end
   end

   // Load wins over a step in the same cycle; the step is simply lost.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      valid_d = 1'b0;
      if (load) begin
         state_d = (seed_in == '0) ? SEED : seed_in;
         count_d = '0;
         valid_d = 1'b1;
      end else if (step_req) begin
         state_d = next_state;
         count_d = count_q + 1'b1;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SEED;
         count_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   assign rand_num   = state_q;
   assign rand_valid = valid_q;
   assign step_count = count_q;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed self-checking bench for lfsr_rand_gen: reset, button stepping,
// full period, bounce rejection, load collisions, counter wrap, reset mid-debounce.
module tb_lfsr_rand_gen;

   logic        clk;
   logic        rst;
   logic        step_btn;
   logic        free_run;
   logic        load;
   logic [7:0]  seed_in;
   logic [7:0]  rand_num;
   logic        rand_valid;
   logic [15:0] step_count;
   logic        btn_level;

   logic [7:0]  rand_num_w4;
   logic        rand_valid_w4;
   logic [3:0]  step_count_w4;
   logic        btn_level_w4;

   int checks = 0;
   int failures = 0;
   int validPulses = 0;

   lfsr_rand_gen dut (
      .clk       (clk),
      .rst       (rst),
      .step_btn  (step_btn),
      .free_run  (free_run),
      .load      (load),
      .seed_in   (seed_in),
      .rand_num  (rand_num),
      .rand_valid(rand_valid),
      .step_count(step_count),
      .btn_level (btn_level)
   );

   lfsr_rand_gen #(.CNT_W(4)) dutW4 (
      .clk       (clk),
      .rst       (rst),
      .step_btn  (step_btn),
      .free_run  (free_run),
      .load      (load),
      .seed_in   (seed_in),
      .rand_num  (rand_num_w4),
      .rand_valid(rand_valid_w4),
      .step_count(step_count_w4),
      .btn_level (btn_level_w4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Running count of rand_valid pulses; tests work with deltas.
   always @(negedge clk) begin
      if (rand_valid) validPulses = validPulses + 1;
   end

   // Reference step for taps 0xB8 written straight from the feedback equation.
   function automatic logic [7:0] lfsrModel(input logic [7:0] s);
      logic f;
      if (s == 8'h00) return 8'h01;
      f = s[7] ^ s[5] ^ s[4] ^ s[3];
      return {s[6:0], f};
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic r, input logic fr, input logic ld,
                                input logic [7:0] sd, input logic btn, input int cycles);
      rst      = r;
      free_run = fr;
      load     = ld;
      seed_in  = sd;
      step_btn = btn;
      for (int i = 0; i < cycles; i++) tick();
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   initial begin
      logic [7:0]   pressSeq [4];
      logic [255:0] seen;
      logic [7:0]   model;
      int           base;
      int           repeats;
      int           zeros;
      int           early;

      pressSeq[0] = 8'h02;
      pressSeq[1] = 8'h04;
      pressSeq[2] = 8'h08;
      pressSeq[3] = 8'h11;

      rst = 1'b1; free_run = 1'b0; load = 1'b0; seed_in = 8'h00; step_btn = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2);
      checkOutput("reset_rand", 32'(rand_num), 32'h01);
      checkOutput("reset_count", 32'(step_count), 32'h0);
      checkOutput("reset_valid", 32'(rand_valid), 32'h0);
      checkOutput("reset_level", 32'(btn_level), 32'h0);

      $display("[TB] button-step presses");
      base = validPulses;
      for (int p = 0; p < 4; p++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 30);
         checkOutput($sformatf("press%0d_rand", p), 32'(rand_num), 32'(pressSeq[p]));
         applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 30);
      end
      checkOutput("press_count", 32'(step_count), 32'd4);
      checkOutput("press_valids", 32'(validPulses - base), 32'd4);

      $display("[TB] full period");
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1);
      checkOutput("period_seed", 32'(rand_num), 32'h01);
      seen = '0;
      seen[1] = 1'b1;
      repeats = 0; zeros = 0; early = 0;
      model = 8'h01;
      for (int i = 1; i <= 255; i++) begin
         applyStimulus(1'b0, (i < 255) ? 1'b1 : 1'b0, 1'b0, 8'h00, 1'b0, 0);
         free_run = 1'b1;
         tick();
         model = lfsrModel(model);
         if (i == 255) free_run = 1'b0;
         if (rand_num == 8'h00) zeros++;
         if (i < 255) begin
            if (rand_num == 8'h01) early++;
            else if (seen[rand_num]) repeats++;
            seen[rand_num] = 1'b1;
         end
         if (i == 128) checkOutput("period_mid", 32'(rand_num), 32'(model));
      end
      checkOutput("period_end", 32'(rand_num), 32'h01);
      checkOutput("period_early", 32'(early), 32'd0);
      checkOutput("period_repeat", 32'(repeats), 32'd0);
      checkOutput("period_zero", 32'(zeros), 32'd0);
      checkOutput("period_count", 32'(step_count), 32'd255);
      checkOutput("period_count_w4", 32'(step_count_w4), 32'd15);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3);
      checkOutput("freerun_stop", 32'(rand_num), 32'h01);

      $display("[TB] bounce rejection");
      base = validPulses;
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, (k % 2 == 0) ? 1'b1 : 1'b0, 5);
      end
      checkOutput("bounce_nostep", 32'(step_count), 32'd255);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 40);
      checkOutput("bounce_count", 32'(step_count), 32'd256);
      checkOutput("bounce_rand", 32'(rand_num), 32'h02);
      checkOutput("bounce_level", 32'(btn_level), 32'h1);
      checkOutput("bounce_valids", 32'(validPulses - base), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 30);
      checkOutput("release_level", 32'(btn_level), 32'h0);

      $display("[TB] load collisions");
      applyStimulus(1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1);
      checkOutput("load_rand", 32'(rand_num), 32'hA5);
      checkOutput("load_count", 32'(step_count), 32'd0);
      checkOutput("load_valid", 32'(rand_valid), 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0);
      free_run = 1'b1;
      tick();
      free_run = 1'b0;
      checkOutput("load_next", 32'(rand_num), 32'h4A);
      checkOutput("load_next_count", 32'(step_count), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1);
      checkOutput("load_zero", 32'(rand_num), 32'h01);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2);
      checkOutput("idle_valid", 32'(rand_valid), 32'h0);

      $display("[TB] counter wrap");
      model = 8'h01;
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 17);
      free_run = 1'b0;
      for (int i = 0; i < 17; i++) model = lfsrModel(model);
      checkOutput("wrap_count_w4", 32'(step_count_w4), 32'd1);
      checkOutput("wrap_count", 32'(step_count), 32'd17);
      checkOutput("wrap_rand", 32'(rand_num), 32'(model));

      $display("[TB] reset mid-debounce");
      base = validPulses;
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 10);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 30);
      checkOutput("rstdb_rand", 32'(rand_num), 32'h01);
      checkOutput("rstdb_count", 32'(step_count), 32'd0);
      checkOutput("rstdb_level", 32'(btn_level), 32'h0);
      checkOutput("rstdb_valids", 32'(validPulses - base), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 30);
      checkOutput("fresh_rand", 32'(rand_num), 32'h02);
      checkOutput("fresh_count", 32'(step_count), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
